// File: rtl/cpu_ext_pkg.sv
// Shared constants and types for the CPU external-access loader.
package cpu_ext_pkg;

  // Host frame opcodes
  localparam logic [7:0] OP_IMEM_WR = 8'h01;
  localparam logic [7:0] OP_DMEM_WR = 8'h02;
  localparam logic [7:0] OP_READ    = 8'h03;
  localparam logic [7:0] OP_RUN     = 8'h10;
  localparam logic [7:0] OP_HALT    = 8'h11;

  // CPU external-port command encodings
  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_IWR = 2'b01;
  localparam logic [1:0] CMD_DWR = 2'b10;
  localparam logic [1:0] CMD_RD  = 2'b11;

  typedef enum logic [2:0] {
    StOp,
    StAddr,
    StData,
    StIssue,
    StWait,
    StResp,
    StAck,
    StErr
  } loader_state_e;

endpackage

// File: rtl/cpu_ext_loader_if.sv
// Host byte link plus CPU external-access port, bundled for the loader.
interface cpu_ext_loader_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  cmd;
  logic [31:0] addr_out;
  logic [31:0] wdata_out;
  logic [31:0] rdata_in;
  logic        cpu_hold;
  logic        busy;

  // Loader side
  modport master (
    input  rx_data, rx_valid, tx_ready, rdata_in,
    output rx_ready, tx_data, tx_valid, cmd, addr_out, wdata_out, cpu_hold, busy
  );

  // Host link and CPU side
  modport slave (
    output rx_data, rx_valid, tx_ready, rdata_in,
    input  rx_ready, tx_data, tx_valid, cmd, addr_out, wdata_out, cpu_hold, busy
  );

endinterface

// File: rtl/ext_tx_serializer.sv
// Byte serializer: loads one byte or a 32-bit word and emits it LSB first over a
// valid/ready link. done_o is high in the cycle the final byte is accepted.
module ext_tx_serializer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        len4_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        done_o
);

  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic [23:0] rest_q, rest_d;
  logic [1:0]  left_q, left_d;  // bytes still to send after the current one
  logic        fire;

  assign fire       = valid_q & tx_ready_i;
  assign done_o     = fire & (left_q == 2'd0);
  assign tx_data_o  = data_q;
  assign tx_valid_o = valid_q;

  // Next byte selection; data and valid only move on load or on an accepted byte
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    rest_d  = rest_q;
    left_d  = left_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = word_i[7:0];
      rest_d  = word_i[31:8];
      left_d  = len4_i ? 2'd3 : 2'd0;
    end else if (fire) begin
      if (left_q == 2'd0) begin
        valid_d = 1'b0;
      end else begin
        data_d = rest_q[7:0];
        rest_d = {8'h00, rest_q[23:8]};
        left_d = left_q - 2'd1;
      end
    end
  end

  // Serializer state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      rest_q  <= 24'h0;
      left_q  <= 2'd0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      rest_q  <= rest_d;
      left_q  <= left_d;
    end
  end

endmodule

// File: rtl/cpu_ext_loader.sv
// Host-side initiator for the CPU external access port. Parses host byte frames into
// IMEM/DMEM writes and reads, returns read data or ack/err bytes, and controls cpu_hold.
module cpu_ext_loader
  import cpu_ext_pkg::*;
#(
  parameter int unsigned RD_LAT   = 1,
  parameter logic [7:0]  ACK_BYTE = 8'hA5,
  parameter logic [7:0]  ERR_BYTE = 8'hEE
) (
  input logic              clk,
  input logic              reset,
  cpu_ext_loader_if.master bus
);

  localparam logic [2:0] RdLat = 3'(RD_LAT);

  loader_state_e state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic [1:0]  op_cmd_q, op_cmd_d;  // command to issue once the frame is complete
  logic [1:0]  cmd_q, cmd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        rx_open, rx_fire;
  logic        ser_load, ser_len4, ser_done;
  logic [31:0] ser_word;

  assign rx_open = (state_q == StOp) || (state_q == StAddr) || (state_q == StData);
  assign rx_fire = rx_open & bus.rx_valid;

  assign bus.rx_ready  = rx_open;
  assign bus.cmd       = cmd_q;
  assign bus.addr_out  = addr_q;
  assign bus.wdata_out = wdata_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.busy      = (state_q != StOp);

  ext_tx_serializer u_tx_ser (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (ser_load),
    .word_i     (ser_word),
    .len4_i     (ser_len4),
    .tx_data_o  (bus.tx_data),
    .tx_valid_o (bus.tx_valid),
    .tx_ready_i (bus.tx_ready),
    .done_o     (ser_done)
  );

  // Frame parser FSM: next state, assembler shifts and serializer loads
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    wait_cnt_d = wait_cnt_q;
    op_cmd_d   = op_cmd_q;
    cmd_d      = CMD_NOP;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cpu_hold_d = cpu_hold_q;
    ser_load   = 1'b0;
    ser_len4   = 1'b0;
    ser_word   = {24'h0, ACK_BYTE};
    unique case (state_q)
      StOp: begin
        if (rx_fire) begin
          byte_cnt_d = 2'd0;
          case (bus.rx_data)
            OP_IMEM_WR: begin op_cmd_d = CMD_IWR; state_d = StAddr; end
            OP_DMEM_WR: begin op_cmd_d = CMD_DWR; state_d = StAddr; end
            OP_READ:    begin op_cmd_d = CMD_RD;  state_d = StAddr; end
            OP_RUN: begin
              cpu_hold_d = 1'b0;
              ser_load   = 1'b1;
              state_d    = StAck;
            end
            OP_HALT: begin
              cpu_hold_d = 1'b1;
              ser_load   = 1'b1;
              state_d    = StAck;
            end
            default: begin
              ser_load = 1'b1;
              ser_word = {24'h0, ERR_BYTE};
              state_d  = StErr;
            end
          endcase
        end
      end
      StAddr: begin
        if (rx_fire) begin
          // Little-endian: shifting in from the top leaves byte 0 in [7:0]
          addr_d     = {bus.rx_data, addr_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (op_cmd_q == CMD_RD) begin
              cmd_d   = op_cmd_q;
              state_d = StIssue;
            end else begin
              state_d = StData;
            end
          end
        end
      end
      StData: begin
        if (rx_fire) begin
          wdata_d    = {bus.rx_data, wdata_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            cmd_d   = op_cmd_q;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (op_cmd_q == CMD_RD) begin
          wait_cnt_d = 3'd1;
          state_d    = StWait;
        end else begin
          ser_load = 1'b1;
          state_d  = StAck;
        end
      end
      StWait: begin
        // rdata_in is valid in the RD_LAT-th cycle after the issue cycle
        if (wait_cnt_q == RdLat) begin
          ser_load = 1'b1;
          ser_len4 = 1'b1;
          ser_word = bus.rdata_in;
          state_d  = StResp;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      StResp, StAck, StErr: begin
        if (ser_done) state_d = StOp;
      end
      default: state_d = StOp;
    endcase
  end

  // State and output registers; reset drops any partial frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StOp;
      byte_cnt_q <= 2'd0;
      wait_cnt_q <= 3'd0;
      op_cmd_q   <= CMD_NOP;
      cmd_q      <= CMD_NOP;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      cpu_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      op_cmd_q   <= op_cmd_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_hold_q <= cpu_hold_d;
    end
  end

endmodule

// File: tb/tb_cpu_ext_loader.sv
// Bench for cpu_ext_loader: two instances (RD_LAT 1 and 2) see identical host traffic,
// each with its own CPU memory model; results are compared against a frame-level model.
module tb_cpu_ext_loader;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_ready;

  logic [1:0][31:0] rdata_v;
  logic [1:0]       rx_ready_w, tx_valid_w, hold_w, busy_w;
  logic [1:0][7:0]  tx_data_w;
  logic [1:0][1:0]  cmd_w;
  logic [1:0][31:0] addr_w, wdata_w;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cpu_ext_loader_if bus ();
    assign bus.rx_data  = rx_data;
    assign bus.rx_valid = rx_valid;
    assign bus.tx_ready = tx_ready;
    assign bus.rdata_in = rdata_v[g];
    assign rx_ready_w[g] = bus.rx_ready;
    assign tx_valid_w[g] = bus.tx_valid;
    assign tx_data_w[g]  = bus.tx_data;
    assign cmd_w[g]      = bus.cmd;
    assign addr_w[g]     = bus.addr_out;
    assign wdata_w[g]    = bus.wdata_out;
    assign hold_w[g]     = bus.cpu_hold;
    assign busy_w[g]     = bus.busy;
    cpu_ext_loader #(
      .RD_LAT   (g + 1),
      .ACK_BYTE (8'hA5),
      .ERR_BYTE (8'hEE)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  int n_checks = 0;
  int n_pass   = 0;
  int tx_mode  = 0;  // 0 always ready, 1 random, 2 five-cycle stall per byte
  int gap_max  = 0;

  // Frame-level reference state
  logic [31:0] ref_mem [16];
  logic        ref_hold;
  logic [31:0] ref_wdata;
  logic [31:0] exp_tx;
  int          exp_txn;
  logic [65:0] exp_cmd;
  int          exp_cmdn;

  // Observed per-instance results
  logic [31:0] cpu_mem [2][16];
  logic [31:0] got_tx [2];
  int          got_txn [2];
  logic [65:0] got_cmd [2];
  int          got_cmdn [2];
  int          stab_err [2];
  int          rxtx_err [2];

  logic [31:0] hist_v [2][8];
  logic        hist_r [2][8];
  logic [1:0]       pv, ph;
  logic [1:0][7:0]  pd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // CPU-side model: memory writes and delayed read data, garbage when not valid
  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) begin hist_r[d][k] = 1'b0; hist_v[d][k] = 32'h0; end
      rdata_v[d] = 32'hDEAD0BAD;
    end
    forever begin
      tick();
      for (int d = 0; d < 2; d++) begin
        for (int k = 7; k > 0; k--) begin
          hist_r[d][k] = hist_r[d][k-1];
          hist_v[d][k] = hist_v[d][k-1];
        end
        hist_r[d][0] = (cmd_w[d] == 2'b11);
        hist_v[d][0] = cpu_mem[d][addr_w[d][5:2]];
        if (cmd_w[d] == 2'b10) cpu_mem[d][addr_w[d][5:2]] = wdata_w[d];
        rdata_v[d] = hist_r[d][d+1] ? hist_v[d][d+1] : 32'hDEAD0BAD;
      end
    end
  end

  // Host tx_ready pattern generator
  initial begin
    int c;
    c = 0;
    tx_ready = 1'b1;
    forever begin
      tick();
      c++;
      case (tx_mode)
        1:       tx_ready = 1'($urandom_range(0, 1));
        2:       tx_ready = (c % 6 == 5);
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // Monitor: records tx bytes, cmd cycles and handshake-stability violations
  initial begin
    pv = '0; ph = '0; pd = '0;
    for (int d = 0; d < 2; d++) begin stab_err[d] = 0; rxtx_err[d] = 0; end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!reset) begin
          pv[d] = 1'b0;
        end else begin
          if (pv[d] && !ph[d] && (!tx_valid_w[d] || tx_data_w[d] !== pd[d])) stab_err[d]++;
          if (tx_valid_w[d] && rx_ready_w[d]) rxtx_err[d]++;
          ph[d] = tx_valid_w[d] & tx_ready;
          pv[d] = tx_valid_w[d];
          pd[d] = tx_data_w[d];
          if (ph[d]) begin
            got_tx[d] = {got_tx[d][23:0], tx_data_w[d]};
            got_txn[d]++;
          end
          if (cmd_w[d] != 2'b00) begin
            got_cmd[d] = {cmd_w[d], addr_w[d], wdata_w[d]};
            got_cmdn[d]++;
          end
        end
      end
    end
  end

  function automatic void exp_push(input logic [7:0] b);
    exp_tx = {exp_tx[23:0], b};
    exp_txn++;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int gap;
    int t;
    gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (gap) tick();
    t = 0;
    while (!(rx_ready_w[0] && rx_ready_w[1]) && t < 100) begin tick(); t++; end
    if (t >= 100) begin
      n_checks++;
      $display("FAIL rx_ready_timeout: byte %h, rx_ready=%b, required 11", b, rx_ready_w);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    tick();
    while ((busy_w != 2'b00 || tx_valid_w != 2'b00) && t < 300) begin tick(); t++; end
    if (t >= 300) begin
      n_checks++;
      $display("FAIL idle_timeout: busy=%b tx_valid=%b, required 00/00", busy_w, tx_valid_w);
    end
    repeat (2) tick();
  endtask

  // Build the model's expectation for one frame, then send it and wait for completion
  task automatic do_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] dv);
    logic [7:0]  fb [9];
    int          n;
    logic [31:0] v;
    for (int d = 0; d < 2; d++) begin
      got_tx[d] = '0; got_txn[d] = 0; got_cmd[d] = '0; got_cmdn[d] = 0;
    end
    exp_tx = '0; exp_txn = 0; exp_cmd = '0; exp_cmdn = 0;
    fb[0] = op;
    n = 1;
    if (op == 8'h01 || op == 8'h02 || op == 8'h03) begin
      for (int k = 0; k < 4; k++) begin fb[n] = a[8*k +: 8]; n++; end
    end
    if (op == 8'h01 || op == 8'h02) begin
      for (int k = 0; k < 4; k++) begin fb[n] = dv[8*k +: 8]; n++; end
      ref_wdata = dv;
      exp_cmd   = {(op == 8'h01) ? 2'b01 : 2'b10, a, dv};
      exp_cmdn  = 1;
      if (op == 8'h02) ref_mem[a[5:2]] = dv;
      exp_push(8'hA5);
    end else if (op == 8'h03) begin
      exp_cmd  = {2'b11, a, ref_wdata};
      exp_cmdn = 1;
      v = ref_mem[a[5:2]];
      for (int k = 0; k < 4; k++) exp_push(v[8*k +: 8]);
    end else if (op == 8'h10 || op == 8'h11) begin
      ref_hold = (op == 8'h11);
      exp_push(8'hA5);
    end else begin
      exp_push(8'hEE);
    end
    for (int i = 0; i < n; i++) send_byte(fb[i]);
    wait_idle();
  endtask

  task automatic test_reset();
    logic [76:0] rv;
    reset = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      rv = {cmd_w[d], addr_w[d], wdata_w[d], tx_valid_w[d], tx_data_w[d], rx_ready_w[d],
            hold_w[d], busy_w[d]};
      n_checks++;
      if (rv !== {2'b00, 32'h0, 32'h0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0})
        $display("FAIL reset_state dut%0d: got %h, required %h", d, rv,
                 {2'b00, 32'h0, 32'h0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0});
      else n_pass++;
    end
    reset = 1'b1;
    tick();
    do_frame(8'h10, 32'h0, 32'h0);
    send_byte(8'h01);
    send_byte(8'h77);
    send_byte(8'h66);
    send_byte(8'h55);
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      rv = {cmd_w[d], addr_w[d], wdata_w[d], tx_valid_w[d], tx_data_w[d], rx_ready_w[d],
            hold_w[d], busy_w[d]};
      n_checks++;
      if (rv !== {2'b00, 32'h0, 32'h0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0})
        $display("FAIL midframe_reset dut%0d: got %h, required %h", d, rv,
                 {2'b00, 32'h0, 32'h0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0});
      else n_pass++;
    end
    repeat (2) tick();
    reset = 1'b1;
    ref_hold  = 1'b1;
    ref_wdata = 32'h0;
    tick();
    do_frame(8'h01, 32'h0000_0040, 32'hCAFE_F00D);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({got_txn[d], got_tx[d]} !== {exp_txn, exp_tx})
        $display("FAIL post_reset_tx dut%0d: got n=%0d %h, required n=%0d %h", d,
                 got_txn[d], got_tx[d], exp_txn, exp_tx);
      else n_pass++;
      n_checks++;
      if ({got_cmdn[d], got_cmd[d]} !== {exp_cmdn, exp_cmd})
        $display("FAIL post_reset_cmd dut%0d: got n=%0d %h, required n=%0d %h", d,
                 got_cmdn[d], got_cmd[d], exp_cmdn, exp_cmd);
      else n_pass++;
    end
  endtask

  task automatic test_imem_write();
    tx_mode = 0;
    gap_max = 0;
    do_frame(8'h01, 32'h0000_0010, 32'hDEAD_BEEF);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({got_txn[d], got_tx[d]} !== {exp_txn, exp_tx})
        $display("FAIL imem_tx dut%0d: got n=%0d %h, required n=%0d %h", d,
                 got_txn[d], got_tx[d], exp_txn, exp_tx);
      else n_pass++;
      n_checks++;
      if ({got_cmdn[d], got_cmd[d]} !== {exp_cmdn, exp_cmd})
        $display("FAIL imem_cmd dut%0d: got n=%0d %h, required n=%0d %h", d,
                 got_cmdn[d], got_cmd[d], exp_cmdn, exp_cmd);
      else n_pass++;
      n_checks++;
      if ({addr_w[d], wdata_w[d]} !== {32'h0000_0010, 32'hDEAD_BEEF})
        $display("FAIL imem_hold_regs dut%0d: got %h %h, required 00000010 deadbeef", d,
                 addr_w[d], wdata_w[d]);
      else n_pass++;
    end
  endtask

  task automatic test_read();
    tx_mode = 0;
    gap_max = 0;
    do_frame(8'h03, 32'h0000_0004, 32'h0);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({got_txn[d], got_tx[d]} !== {32'd4, 32'h7856_3412})
        $display("FAIL read_tx lat%0d: got n=%0d %h, required n=4 78563412", d + 1,
                 got_txn[d], got_tx[d]);
      else n_pass++;
      n_checks++;
      if ({got_cmdn[d], got_cmd[d]} !== {exp_cmdn, exp_cmd})
        $display("FAIL read_cmd lat%0d: got n=%0d %h, required n=%0d %h", d + 1,
                 got_cmdn[d], got_cmd[d], exp_cmdn, exp_cmd);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    tx_mode = 2;
    gap_max = 0;
    for (int d = 0; d < 2; d++) begin stab_err[d] = 0; rxtx_err[d] = 0; end
    do_frame(8'h03, 32'h0000_0004, 32'h0);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({got_txn[d], got_tx[d]} !== {exp_txn, exp_tx})
        $display("FAIL bp_tx dut%0d: got n=%0d %h, required n=%0d %h", d,
                 got_txn[d], got_tx[d], exp_txn, exp_tx);
      else n_pass++;
      n_checks++;
      if (stab_err[d] !== 0)
        $display("FAIL bp_stable dut%0d: got %0d unstable stall cycles, required 0", d,
                 stab_err[d]);
      else n_pass++;
      n_checks++;
      if (rxtx_err[d] !== 0)
        $display("FAIL bp_rx_ready dut%0d: got %0d cycles rx_ready=1 during tx, required 0",
                 d, rxtx_err[d]);
      else n_pass++;
    end
    tx_mode = 0;
  endtask

  task automatic test_run_halt();
    logic [7:0] ops [3];
    ops[0] = 8'h10; ops[1] = 8'h11; ops[2] = 8'h11;
    tx_mode = 0;
    for (int i = 0; i < 3; i++) begin
      do_frame(ops[i], 32'h0, 32'h0);
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if ({got_txn[d], got_tx[d], got_cmdn[d]} !== {exp_txn, exp_tx, 32'd0})
          $display("FAIL runhalt_tx op%h dut%0d: got n=%0d %h cmds=%0d, required n=%0d %h 0",
                   ops[i], d, got_txn[d], got_tx[d], got_cmdn[d], exp_txn, exp_tx);
        else n_pass++;
        n_checks++;
        if (hold_w[d] !== ref_hold)
          $display("FAIL runhalt_hold op%h dut%0d: got %b, required %b", ops[i], d,
                   hold_w[d], ref_hold);
        else n_pass++;
      end
    end
  endtask

  task automatic test_bad_opcode();
    tx_mode = 1;
    gap_max = 4;
    do_frame(8'h7F, 32'h0, 32'h0);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({got_txn[d], got_tx[d], got_cmdn[d]} !== {32'd1, 32'h0000_00EE, 32'd0})
        $display("FAIL bad_op dut%0d: got n=%0d %h cmds=%0d, required n=1 000000ee 0", d,
                 got_txn[d], got_tx[d], got_cmdn[d]);
      else n_pass++;
    end
    do_frame(8'h02, $urandom, $urandom);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({got_txn[d], got_tx[d]} !== {exp_txn, exp_tx})
        $display("FAIL dmem_tx dut%0d: got n=%0d %h, required n=%0d %h", d,
                 got_txn[d], got_tx[d], exp_txn, exp_tx);
      else n_pass++;
      n_checks++;
      if ({got_cmdn[d], got_cmd[d]} !== {exp_cmdn, exp_cmd})
        $display("FAIL dmem_cmd dut%0d: got n=%0d %h, required n=%0d %h", d,
                 got_cmdn[d], got_cmd[d], exp_cmdn, exp_cmd);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [7:0] op;
    int         sel;
    for (int i = 0; i < 24; i++) begin
      tx_mode = int'($urandom_range(0, 2));
      gap_max = int'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: op = 8'h01;
        1: op = 8'h02;
        2: op = 8'h03;
        3: op = 8'h10;
        4: op = 8'h11;
        default: begin
          op = 8'($urandom);
          while (op inside {8'h01, 8'h02, 8'h03, 8'h10, 8'h11}) op = 8'($urandom);
        end
      endcase
      for (int d = 0; d < 2; d++) stab_err[d] = 0;
      do_frame(op, $urandom, $urandom);
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if ({got_txn[d], got_tx[d], got_cmdn[d], got_cmd[d]} !==
            {exp_txn, exp_tx, exp_cmdn, exp_cmd})
          $display("FAIL rand%0d op%h dut%0d: got n=%0d %h c=%0d %h, required n=%0d %h c=%0d %h",
                   i, op, d, got_txn[d], got_tx[d], got_cmdn[d], got_cmd[d],
                   exp_txn, exp_tx, exp_cmdn, exp_cmd);
        else n_pass++;
        n_checks++;
        if ({hold_w[d], stab_err[d]} !== {ref_hold, 32'd0})
          $display("FAIL rand%0d_hold_stable dut%0d: got hold=%b unstable=%0d, required %b 0",
                   i, d, hold_w[d], stab_err[d], ref_hold);
        else n_pass++;
      end
    end
    tx_mode = 0;
    gap_max = 0;
  endtask

  initial begin
    reset     = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    ref_hold  = 1'b1;
    ref_wdata = 32'h0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i]    = 32'hC0DE_0000 | 32'(i);
      cpu_mem[0][i] = 32'hC0DE_0000 | 32'(i);
      cpu_mem[1][i] = 32'hC0DE_0000 | 32'(i);
    end
    ref_mem[1]    = 32'h1234_5678;
    cpu_mem[0][1] = 32'h1234_5678;
    cpu_mem[1][1] = 32'h1234_5678;

    test_reset();
    test_imem_write();
    test_read();
    test_backpressure();
    test_run_halt();
    test_bad_opcode();
    test_random();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
